// File: rtl/vga_fb_pkg.sv
// Shared constants and the clear-engine state type for the VGA frame-buffer
// arbiter slice.
package vga_fb_pkg;

    localparam int H_DISP  = 640;
    localparam int V_DISP  = 480;
    localparam int FB_W    = 160;
    localparam int FB_H    = 120;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int AW      = 15;
    localparam int DW      = 6;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clr_state_t;

endpackage

// File: rtl/fb_clear_fsm.sv
// Clear-screen engine: walks the whole frame buffer writing one latched colour,
// advancing only in cycles the arbiter grants to it.
module fb_clear_fsm
    import vga_fb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          grant,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          req,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          busy,
    output logic          clr_done,
    output logic          start_accept
);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] count, count_nxt;
    logic [DW-1:0] color, color_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            color <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            color <= color_nxt;
        end
    end

    // A start request arriving mid-clear is deliberately ignored; only IDLE listens.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        color_nxt    = color;
        req          = 1'b0;
        busy         = 1'b0;
        clr_done     = 1'b0;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    start_accept = 1'b1;
                    state_nxt    = CLEAR;
                    count_nxt    = '0;
                    color_nxt    = clr_color;
                end
            end
            CLEAR: begin
                req  = 1'b1;
                busy = 1'b1;
                if (grant) begin
                    if (count == AW'(FB_SIZE - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
            DONE: begin
                clr_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign addr = count;
    assign data = color;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates the single-port frame-buffer RAM between fixed display read slots,
// the clear engine and host pixel writes, and produces the upscaled pixel stream.
module vga_fb_arbiter
    import vga_fb_pkg::*;
(
    input  logic          pixel_clk,
    input  logic          sys_rst_n,
    input  logic [9:0]    pixel_xpos,
    input  logic [9:0]    pixel_ypos,
    output logic [DW-1:0] pixel_data,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          busy,
    output logic          clr_done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    logic          disp_active;
    logic          disp_slot;
    logic [7:0]    fb_x;
    logic [7:0]    fb_y;
    logic [AW-1:0] disp_addr;
    logic          clr_req;
    logic          clr_grant;
    logic          clr_start_accept;
    logic [AW-1:0] clr_addr;
    logic [DW-1:0] clr_data;
    logic          wr_in_range;
    logic          host_grant;
    logic          slot_d1;
    logic          active_d1;

    assign disp_active = (pixel_xpos < 10'(H_DISP)) && (pixel_ypos < 10'(V_DISP));
    assign disp_slot   = disp_active && (pixel_xpos[1:0] == 2'b00);

    // y*160 computed as y*128 + y*32 so no multiplier is inferred.
    assign fb_x      = pixel_xpos[9:2];
    assign fb_y      = pixel_ypos[9:2];
    assign disp_addr = {fb_y, 7'b0} + {2'b00, fb_y, 5'b0} + {7'b0, fb_x};

    assign clr_grant   = clr_req && !disp_slot;
    assign wr_in_range = (wr_addr < AW'(FB_SIZE));

    // Host is held off for the whole clear, including the start and done cycles,
    // so a write queued behind a clear is never performed before clr_done.
    assign host_grant = sys_rst_n && wr_req && !disp_slot && !clr_req
                        && !clr_start_accept && !clr_done;
    assign wr_ack     = host_grant;

    fb_clear_fsm u_clear (
        .clk          (pixel_clk),
        .rst_n        (sys_rst_n),
        .grant        (clr_grant),
        .clr_start    (clr_start),
        .clr_color    (clr_color),
        .req          (clr_req),
        .addr         (clr_addr),
        .data         (clr_data),
        .busy         (busy),
        .clr_done     (clr_done),
        .start_accept (clr_start_accept)
    );

    always_comb begin
        ram_addr  = wr_addr;
        ram_wdata = wr_data;
        ram_we    = 1'b0;
        if (disp_slot) begin
            ram_addr = disp_addr;
        end else if (clr_req) begin
            ram_addr  = clr_addr;
            ram_wdata = clr_data;
            ram_we    = 1'b1;
        end else if (host_grant) begin
            ram_we = wr_in_range;
        end
    end

    // Read data returns one cycle after the slot; capture it then and hold for four pixels.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slot_d1    <= 1'b0;
            active_d1  <= 1'b0;
            pixel_data <= '0;
        end else begin
            slot_d1   <= disp_slot;
            active_d1 <= disp_active;
            if (!active_d1) begin
                pixel_data <= '0;
            end else if (slot_d1) begin
                pixel_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: a RAM model, a queue-based scoreboard
// and a behavioural model of slot/clear/host arbitration.
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    logic          pixel_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [9:0]    pixel_xpos = '0;
    logic [9:0]    pixel_ypos = '0;
    logic [DW-1:0] pixel_data;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_color = '0;
    logic          busy;
    logic          clr_done;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    vga_fb_arbiter dut (
        .pixel_clk  (pixel_clk),
        .sys_rst_n  (sys_rst_n),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .pixel_data (pixel_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .busy       (busy),
        .clr_done   (clr_done),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 pixel_clk = ~pixel_clk;

    logic [5:0] mem [0:32767];
    always @(posedge pixel_clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct { logic chk; logic [5:0] val; } pix_exp_t;
    typedef struct { logic [14:0] addr; logic [5:0] data; } wr_exp_t;
    pix_exp_t exp_pix[$];
    wr_exp_t  wr_exp[$];
    logic [5:0] ref_img [0:FB_SIZE-1];

    int checks = 0;
    int errors = 0;

    function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Driver-side state
    logic          drv_req = 1'b0;
    logic [14:0]   drv_addr = '0;
    logic [5:0]    drv_data = '0;
    logic          drv_cstart = 1'b0;
    logic [5:0]    drv_ccolor = '0;
    logic          pix_chk = 1'b0;
    logic          prev_req = 1'b0;
    logic          last_ack = 1'b0;
    int            sx = 0;
    int            sy = 0;

    // Model of the clear engine: 0 idle, 1 clearing, 2 done
    int            mst = 0;
    int            mcnt = 0;
    logic [5:0]    mcolor = '0;
    int            clr_writes = 0;
    int            done_pulses = 0;
    logic          m_slot, m_ack, m_busy, m_done, m_clr_we, m_we;
    pix_exp_t      pe;
    wr_exp_t       we_e;

    always @(negedge pixel_clk) begin
        if (sys_rst_n) begin
            m_slot   = (pixel_xpos < 640) && (pixel_ypos < 480) && (pixel_xpos % 4 == 0);
            m_ack    = 1'b0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_clr_we = 1'b0;
            case (mst)
                0:       m_ack = wr_req && !m_slot && !clr_start;
                1:       begin m_busy = 1'b1; m_clr_we = !m_slot; end
                default: m_done = 1'b1;
            endcase
            m_we = m_clr_we || (m_ack && (wr_addr < 19200));
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("clr_done", 32'(clr_done), 32'(m_done));
            checkOutput("wr_ack", 32'(wr_ack), 32'(m_ack));
            checkOutput("ram_we", 32'(ram_we), 32'(m_we));
            if (m_slot)
                checkOutput("slot_addr", 32'(ram_addr), 32'((pixel_ypos / 4) * 160 + pixel_xpos / 4));
            if (m_clr_we) begin
                checkOutput("clr_addr", 32'(ram_addr), 32'(mcnt));
                checkOutput("clr_data", 32'(ram_wdata), 32'(mcolor));
                ref_img[mcnt] = mcolor;
                mcnt++;
                clr_writes++;
            end
            if (wr_ack) begin
                if (wr_exp.size() == 0) begin
                    checkOutput("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    we_e = wr_exp.pop_front();
                    if (we_e.addr < 19200) begin
                        checkOutput("wr_ram_addr", 32'(ram_addr), 32'(we_e.addr));
                        checkOutput("wr_ram_data", 32'(ram_wdata), 32'(we_e.data));
                        ref_img[we_e.addr] = we_e.data;
                    end
                end
            end
            if (clr_done) done_pulses++;
            if (exp_pix.size() > 2) begin
                pe = exp_pix.pop_front();
                if (pe.chk) checkOutput("pixel_data", 32'(pixel_data), 32'(pe.val));
            end
            case (mst)
                0: if (clr_start) begin mst = 1; mcnt = 0; mcolor = clr_color; end
                1: if (mcnt == 19200) mst = 2;
                default: mst = 0;
            endcase
        end
    end

    // One pixel-clock cycle of stimulus; returns at the following falling edge.
    task automatic applyStimulus(input int x, input int y);
        pix_exp_t e;
        wr_exp_t  w;
        @(posedge pixel_clk);
        #1;
        pixel_xpos = 10'(x);
        pixel_ypos = 10'(y);
        wr_req     = drv_req;
        wr_addr    = drv_addr;
        wr_data    = drv_data;
        clr_start  = drv_cstart;
        clr_color  = drv_ccolor;
        if (drv_req && (!prev_req || last_ack)) begin
            w.addr = drv_addr;
            w.data = drv_data;
            wr_exp.push_back(w);
        end
        prev_req = drv_req;
        e.chk = pix_chk;
        e.val = (x < 640 && y < 480) ? ref_img[(y / 4) * 160 + x / 4] : 6'd0;
        exp_pix.push_back(e);
        @(negedge pixel_clk);
        last_ack = wr_ack;
    endtask

    task automatic scanStep();
        applyStimulus(sx, sy);
        sx++;
        if (sx == 800) begin
            sx = 0;
            sy = (sy == 524) ? 0 : sy + 1;
        end
    endtask

    task automatic sweepLine(input int y);
        for (int x = 0; x < 800; x++) applyStimulus(x, y);
    endtask

    task automatic doReset();
        @(posedge pixel_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_clr_done", 32'(clr_done), 32'd0);
        checkOutput("rst_pixel_data", 32'(pixel_data), 32'd0);
        checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
        checkOutput("rst_wr_ack", 32'(wr_ack), 32'd0);
        drv_req = 1'b0;
        drv_cstart = 1'b0;
        wr_req = 1'b0;
        clr_start = 1'b0;
        repeat (3) @(negedge pixel_clk);
        exp_pix.delete();
        wr_exp.delete();
        mst = 0;
        prev_req = 1'b0;
        last_ack = 1'b0;
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  ackcnt;
        int  bound;
        logic acked;
        for (int a = 0; a < 32768; a++) mem[a] = 6'(a);
        for (int a = 0; a < FB_SIZE; a++) ref_img[a] = 6'(a);

        // Reset state, with a host request pending that must not reach the RAM
        pixel_xpos = 10'd1;
        wr_req = 1'b1;
        wr_addr = 15'd5;
        wr_data = 6'd1;
        #23;
        checkOutput("init_ram_we", 32'(ram_we), 32'd0);
        checkOutput("init_wr_ack", 32'(wr_ack), 32'd0);
        checkOutput("init_busy", 32'(busy), 32'd0);
        checkOutput("init_clr_done", 32'(clr_done), 32'd0);
        checkOutput("init_pixel_data", 32'(pixel_data), 32'd0);
        wr_req = 1'b0;
        @(negedge pixel_clk);
        #1;
        sys_rst_n = 1'b1;

        $display("[TB] display sweep");
        pix_chk = 1'b1;
        sweepLine(8);
        sweepLine(479);
        for (int x = 0; x < 8; x++) applyStimulus(x, 480);

        $display("[TB] constant host write during active line");
        pix_chk = 1'b0;
        drv_req = 1'b1; drv_addr = 15'd100; drv_data = 6'h2A;
        ackcnt = 0;
        for (int x = 0; x < 16; x++) begin
            applyStimulus(x, 20);
            if (last_ack) ackcnt++;
        end
        drv_req = 1'b0;
        applyStimulus(700, 20);
        checkOutput("const_ack_count", 32'(ackcnt), 32'd12);
        checkOutput("ram100", 32'(mem[100]), 32'h2A);
        checkOutput("wr_queue_empty", 32'(wr_exp.size()), 32'd0);

        $display("[TB] out-of-range host write");
        drv_req = 1'b1; drv_addr = 15'd19200; drv_data = 6'h3F;
        acked = 1'b0;
        for (int c = 0; c < 20 && !acked; c++) begin
            applyStimulus(c, 20);
            acked = last_ack;
        end
        drv_req = 1'b0;
        applyStimulus(700, 20);
        checkOutput("oor_acked", 32'(acked), 32'd1);
        checkOutput("oor_mem", 32'(mem[19200]), 32'd0);

        $display("[TB] random host writes");
        for (int t = 0; t < 200; t++) begin
            drv_req = 1'b1;
            drv_addr = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(19200, 32767))
                                                    : 15'($urandom_range(0, 639));
            drv_data = 6'($urandom);
            acked = 1'b0;
            for (int c = 0; c < 50 && !acked; c++) begin
                applyStimulus($urandom_range(0, 799), $urandom_range(0, 524));
                acked = last_ack;
            end
            checkOutput("rand_ack_seen", 32'(acked), 32'd1);
        end
        drv_req = 1'b0;
        applyStimulus(700, 500);
        pix_chk = 1'b1;
        for (int y = 0; y < 16; y += 4) sweepLine(y);

        $display("[TB] clear with queued host write and repeated start");
        pix_chk = 1'b0;
        clr_writes = 0;
        done_pulses = 0;
        sx = 0; sy = 100;
        drv_cstart = 1'b1; drv_ccolor = 6'h15;
        drv_req = 1'b1; drv_addr = 15'd100; drv_data = 6'h2A;
        scanStep();
        drv_cstart = 1'b0;
        acked = last_ack;
        for (int i = 0; i < 40000 && !acked; i++) begin
            if (mcnt == 8000 && mst == 1) begin drv_cstart = 1'b1; drv_ccolor = 6'h0A; end
            scanStep();
            drv_cstart = 1'b0;
            acked = last_ack;
        end
        drv_req = 1'b0;
        repeat (4) scanStep();
        checkOutput("clr_queued_ack", 32'(acked), 32'd1);
        checkOutput("clr_write_total", 32'(clr_writes), 32'd19200);
        checkOutput("clr_done_pulses", 32'(done_pulses), 32'd1);
        checkOutput("busy_after_clear", 32'(busy), 32'd0);
        pix_chk = 1'b1;
        sweepLine(0);
        sweepLine(476);
        pix_chk = 1'b0;
        for (int a = 0; a < FB_SIZE; a++) checkOutput("mem_after_clear", 32'(mem[a]), 32'(ref_img[a]));

        $display("[TB] reset mid-clear");
        sx = 0; sy = 200;
        drv_cstart = 1'b1; drv_ccolor = 6'h33;
        scanStep();
        drv_cstart = 1'b0;
        bound = 0;
        while (!(mst == 1 && mcnt >= 5000) && bound < 10000) begin
            scanStep();
            bound++;
        end
        checkOutput("reach_5000", 32'(bound < 10000), 32'd1);
        doReset();
        drv_cstart = 1'b1; drv_ccolor = 6'h07;
        scanStep();
        drv_cstart = 1'b0;
        repeat (300) scanStep();
        checkOutput("restart_progress", 32'(mst == 1 && mcnt > 0), 32'd1);
        doReset();
        for (int a = 0; a < FB_SIZE; a++) checkOutput("mem_final", 32'(mem[a]), 32'(ref_img[a]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port 160x120x6 frame-buffer RAM between three users.
- Display read path: feeds pixel_data to vga_driver, 4x upscaled to 640x480.
- Host pixel-write port.
- Internal clear-screen engine.

Display reads get fixed, guaranteed slots. Writes and clear use the remaining RAM cycles. Sits between vga_driver and the frame RAM, replacing vga_display's pattern generator.

Parameters:
- H_DISP, 640, active pixels per line.
- V_DISP, 480, active lines per frame.
- FB_W, 160, frame-buffer width (H_DISP>>2).
- FB_H, 120, frame-buffer height (V_DISP>>2).
- AW, 15, RAM address width.
- DW, 6, pixel width (RGB222).

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- pixel_xpos  in  10  0-based column; displayed 2 cycles later.
- pixel_ypos  in  10  0-based line, same timing as pixel_xpos.
- pixel_data  out  DW  pixel colour to vga_driver.
- wr_req  in  1  host write request; held until wr_ack.
- wr_addr  in  AW  linear frame-buffer address, y*FB_W+x.
- wr_data  in  DW  write colour.
- wr_ack  out  1  one-cycle pulse; the write is performed in that cycle.
- clr_start  in  1  pulse; starts a full-screen clear.
- clr_color  in  DW  fill colour; sampled on clr_start acceptance.
- busy  out  1  high while a clear is in progress.
- clr_done  out  1  one-cycle pulse after the last clear write.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data; 1-cycle read latency.

Behaviour:
- Reset (async): pixel_data=0, wr_ack=0, busy=0, clr_done=0, FSM=IDLE, clear counter=0, latched colour=0. ram_we=0 while in reset.
- disp_active = (pixel_xpos<H_DISP) && (pixel_ypos<V_DISP).
- Display slot = disp_active && pixel_xpos[1:0]==0.
  - ram_addr = (pixel_ypos>>2)*FB_W + (pixel_xpos>>2). Implement with shift-add (y<<7 + y<<5); no multiplier.
  - ram_we=0 in a display slot.
- Display pipeline:
  - Cycle 0: slot issues the read.
  - Cycle 1: ram_rdata is valid.
  - Cycle 2: pixel_data is registered from it and holds 4 cycles until the next slot's data.
  - A delayed copy of the slot flag gates the capture.
  - When the delayed disp_active is 0, pixel_data is registered to 0.
- Non-slot cycles, priority order:
  - CLEAR FSM write first.
  - Else host write if wr_req.
  - Else idle (ram_we=0, ram_addr don't-care).
- Host write: in a granted cycle, drive ram_addr=wr_addr, ram_we=1, ram_wdata=wr_data, and wr_ack=1 combinationally in the same cycle. The requester drops or changes wr_req on the next edge.
- Out-of-range host write: wr_addr >= FB_W*FB_H is acked but ram_we is forced to 0 (write discarded).
- Host writes are never acked while busy=1.
- FSM IDLE:
  - clr_start → CLEAR; latch clr_color; counter=0; busy=1.
  - clr_start and wr_req in the same cycle: clear wins; the write waits.
- FSM CLEAR:
  - Each non-slot cycle writes the latched colour at the counter address, then increments the counter.
  - On the write at FB_W*FB_H-1 (19199): go to DONE.
  - clr_start in CLEAR is ignored (no restart).
- FSM DONE: clr_done=1 and busy=0 for one cycle, then IDLE.
- Clear duration: ≥19200 cycles. At most 1 in 4 cycles is stolen during active video.
- Reset mid-clear: immediate IDLE; partially cleared RAM is left as is.
- Display slots are never delayed or skipped under any write load.

Decomposition:
- Package vga_fb_pkg: H_DISP, V_DISP, FB_W, FB_H, FB_SIZE (=FB_W*FB_H), AW, DW; FSM state enum {IDLE, CLEAR, DONE}.
- Sub-module fb_clear_fsm: state register, counter, latched colour, busy/clr_done.
  - Inputs: grant, clr_start, clr_color.
  - Outputs: req, addr, data.
- The top level holds slot decode, address arithmetic, priority mux and the pixel_data pipeline.

Test Plan:
- RAM model preloaded with value = addr[5:0]; sweep x=0..639, y=8 → pixel_data at x+2 equals ((2*160+(x>>2))&63); each value held exactly 4 cycles.
- Constant wr_req, addr 100, data 6'h2A during active line → acks only when xpos[1:0]!=0; no ram_we in any slot; RAM[100]=6'h2A.
- wr_addr=19200, data 6'h3F → wr_ack pulses, ram_we stays 0, RAM unchanged.
- clr_start with clr_color=6'h15 during active frame → busy high; 19200 writes of 6'h15; clr_done single pulse; busy low after; wr_req held throughout is acked only after clr_done.
- clr_start repeated mid-clear → ignored; counter continues; exactly 19200 writes total.
- sys_rst_n asserted at counter=5000 → busy=0, pixel_data=0 immediately; after release a new clr_start restarts at address 0.
